// File: rtl/run_slot_if.sv
// Requester/engine bundle for the run-slot scheduler; master drives requests and engine status.
// Scheduler uses the slave side. Purely combinational wiring: no latency, no backpressure of its own.
interface run_slot_if #(
  parameter int NREQ    = 4,
  parameter int SLICE_W = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    done;
  logic [SLICE_W-1:0] slice_len;
  logic               running;
  logic [NREQ-1:0]    grant;
  logic               go;
  logic               stop;
  logic               busy;
  logic               preempt;

  modport master (
    output req, done, slice_len, running,
    input  grant, go, stop, busy, preempt
  );

  modport slave (
    input  req, done, slice_len, running,
    output grant, go, stop, busy, preempt
  );
endinterface

// File: rtl/run_slot_scheduler.sv
// Round-robin time-slice owner of one go/stop/running engine. Latency: req to grant/go 1 cycle, all outputs registered.
// Backpressure: START and STOP_WAIT wait on running indefinitely; requests are levels held until served.
module run_slot_scheduler #(
  parameter int NREQ    = 4,
  parameter int SLICE_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  run_slot_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, START, RUN, STOP_WAIT} state_t;

  state_t             state, state_nxt;
  logic [NREQ-1:0]    grant_q, grant_nxt;
  logic               go_q, go_nxt;
  logic               stop_q, stop_nxt;
  logic               busy_q, busy_nxt;
  logic               preempt_q, preempt_nxt;
  logic [SLICE_W-1:0] cnt_q, cnt_nxt;
  logic [SLICE_W-1:0] slen_q, slen_nxt;
  logic [IW-1:0]      last_q, last_nxt;

  logic [IW-1:0]      pick;
  logic               any_req;
  logic               owner_req;
  logic               owner_done;
  logic               others_wait;
  logic               expire;

  // Scan downward so the nearest set bit after last overwrites the farther ones.
  always_comb begin
    int idx;
    idx  = 0;
    pick = last_q;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NREQ;
      if (bus.req[idx]) pick = IW'(idx);
    end
  end

  assign any_req     = |bus.req;
  assign owner_req   = |(bus.req & grant_q);
  assign owner_done  = |(bus.done & grant_q);
  assign others_wait = |(bus.req & ~grant_q);
  assign expire      = (slen_q != '0) && (cnt_q == SLICE_W'(1));

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_q;
    go_nxt      = go_q;
    stop_nxt    = stop_q;
    preempt_nxt = 1'b0;
    cnt_nxt     = cnt_q;
    slen_nxt    = slen_q;
    last_nxt    = last_q;

    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt = NREQ'(1) << pick;
          last_nxt  = pick;
          cnt_nxt   = bus.slice_len;
          slen_nxt  = bus.slice_len;
          go_nxt    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (!owner_req) begin
          go_nxt    = 1'b0;
          stop_nxt  = 1'b1;
          state_nxt = STOP_WAIT;
        end else if (bus.running) begin
          go_nxt    = 1'b0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (owner_done || !owner_req) begin
          stop_nxt  = 1'b1;
          state_nxt = STOP_WAIT;
        end else if (expire && others_wait) begin
          stop_nxt    = 1'b1;
          preempt_nxt = 1'b1;
          state_nxt   = STOP_WAIT;
        end else if (expire) begin
          cnt_nxt = slen_q;
        end else if (cnt_q > SLICE_W'(1)) begin
          cnt_nxt = cnt_q - SLICE_W'(1);
        end
      end
      STOP_WAIT: begin
        if (!bus.running) begin
          stop_nxt  = 1'b0;
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_q   <= '0;
      go_q      <= 1'b0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      cnt_q     <= '0;
      slen_q    <= '0;
      last_q    <= IW'(NREQ - 1);
    end else begin
      state     <= state_nxt;
      grant_q   <= grant_nxt;
      go_q      <= go_nxt;
      stop_q    <= stop_nxt;
      busy_q    <= busy_nxt;
      preempt_q <= preempt_nxt;
      cnt_q     <= cnt_nxt;
      slen_q    <= slen_nxt;
      last_q    <= last_nxt;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.go      = go_q;
  assign bus.stop    = stop_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_run_slot_scheduler.sv
// Bench for run_slot_scheduler: engine model answers go/stop after 2 cycles; grants are scoreboarded.
module tb_run_slot_scheduler;

  logic clk;
  logic rst;

  run_slot_if #(.NREQ(4), .SLICE_W(8)) bus ();

  run_slot_scheduler #(.NREQ(4), .SLICE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_q[$];

  logic [3:0] prev_grant   = '0;
  logic       prev_stop    = 1'b0;
  logic       prev_running = 1'b0;
  logic       run_fell     = 1'b0;
  logic       rel_valid    = 1'b0;
  logic       chk_gap      = 1'b0;
  int         gap          = 0;
  int         stop_rises   = 0;
  int         preempt_cnt  = 0;
  int         ecnt         = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Engine: running follows go after 2 cycles and drops 2 cycles after stop.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      bus.running = 1'b0;
      ecnt = 0;
    end else if (bus.go && !bus.running) begin
      ecnt++;
      if (ecnt >= 2) begin
        bus.running = 1'b1;
        ecnt = 0;
      end
    end else if (bus.stop && bus.running) begin
      ecnt++;
      if (ecnt >= 2) begin
        bus.running = 1'b0;
        ecnt = 0;
      end
    end else begin
      ecnt = 0;
    end
  end

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (run_fell) check("grant_clr_after_run_fall", 32'(bus.grant), 32'd0);
      run_fell = prev_running && !bus.running;
    end
    check("go_stop_excl", 32'(bus.go & bus.stop), 32'd0);
    check("grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
    check("busy_vs_grant", 32'(bus.busy), 32'(|bus.grant));
    if (bus.preempt) begin
      preempt_cnt++;
      check("preempt_on_stop_rise", 32'({bus.stop, prev_stop}), 32'd2);
    end
    if (bus.stop && !prev_stop) stop_rises++;
    if (bus.grant != 0 && prev_grant == 0) begin
      if (exp_q.size() == 0) check("grant_unexpected", 32'(bus.grant), 32'd0);
      else check("grant_order", 32'(bus.grant), 32'(exp_q.pop_front()));
      if (chk_gap && rel_valid) check("idle_gap", 32'(gap), 32'd1);
    end
    if (prev_grant != 0 && bus.grant == 0) begin
      gap = 1;
      rel_valid = !rst;
    end else if (bus.grant == 0) begin
      gap++;
    end
    if (rst) begin
      run_fell  = 1'b0;
      rel_valid = 1'b0;
    end
    prev_grant   = bus.grant;
    prev_stop    = bus.stop;
    prev_running = bus.running;
  end

  // sel: 0 busy, 1 running, 2 stop
  task automatic wait_sig(input int sel, input logic val, input string tag);
    logic cur;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      case (sel)
        0:       cur = bus.busy;
        1:       cur = bus.running;
        default: cur = bus.stop;
      endcase
      if (cur === val) return;
    end
    check(tag, 32'(cur), 32'(val));
  endtask

  initial begin
    int s0, p0, n;

    // Reset values, then first grant goes to requester 0
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.done = '0;
    bus.slice_len = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_go", 32'(bus.go), 32'd0);
    check("rst_stop", 32'(bus.stop), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_preempt", 32'(bus.preempt), 32'd0);
    rst = 1'b0;
    exp_q.push_back(4'b0001);
    wait_sig(0, 1'b1, "t1_busy_rise_timeout");
    check("t1_go_with_grant", 32'(bus.go), 32'd1);
    bus.req = 4'b0000;
    wait_sig(0, 1'b0, "t1_busy_fall_timeout");

    // Single owner released by done
    s0 = stop_rises; p0 = preempt_cnt;
    bus.req = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_sig(1, 1'b1, "t2_run_timeout");
    repeat (10) @(negedge clk);
    check("t2_no_stop_while_running", 32'(bus.stop), 32'd0);
    bus.done = 4'b0100;
    bus.req = 4'b0000;
    @(negedge clk);
    bus.done = '0;
    wait_sig(0, 1'b0, "t2_busy_fall_timeout");
    check("t2_stop_phases", 32'(stop_rises - s0), 32'd1);
    check("t2_preempt", 32'(preempt_cnt - p0), 32'd0);

    // Round-robin from a fresh pointer, skipping requester 2
    rst = 1'b1;
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b1011;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    chk_gap = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_sig(1, 1'b1, "t3_run_timeout");
      repeat (3) @(negedge clk);
      bus.done = 4'b1111;
      if (t == 3) bus.req = 4'b0000;
      @(negedge clk);
      bus.done = '0;
      wait_sig(0, 1'b0, "t3_busy_fall_timeout");
    end
    chk_gap = 1'b0;

    // Preemption after 5 RUN cycles with requester 3 waiting
    p0 = preempt_cnt;
    bus.slice_len = 8'd5;
    bus.req = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_sig(0, 1'b1, "t4_busy_rise_timeout");
    bus.req = 4'b1001;
    exp_q.push_back(4'b1000);
    wait_sig(1, 1'b1, "t4_run_timeout");
    // running seen here is sampled at the next edge, so stop shows up slice_len+1 samples later
    n = 0;
    while (!bus.stop && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_slice_cycles", 32'(n), 32'd6);
    wait_sig(0, 1'b0, "t4_busy_fall_timeout");
    wait_sig(0, 1'b1, "t4_regrant_timeout");
    bus.req = 4'b0000;
    wait_sig(0, 1'b0, "t4_busy_fall2_timeout");
    check("t4_preempt_pulses", 32'(preempt_cnt - p0), 32'd1);

    // Expiry with no contender keeps the engine running
    s0 = stop_rises; p0 = preempt_cnt;
    bus.slice_len = 8'd3;
    bus.req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_sig(1, 1'b1, "t5_run_timeout");
    repeat (20) @(negedge clk);
    check("t5_no_stop", 32'(stop_rises - s0), 32'd0);
    check("t5_no_preempt", 32'(preempt_cnt - p0), 32'd0);
    check("t5_still_running", 32'(bus.running), 32'd1);
    bus.done = 4'b0010;
    bus.req = 4'b0000;
    @(negedge clk);
    bus.done = '0;
    wait_sig(0, 1'b0, "t5_busy_fall_timeout");

    // done lands on the expiry cycle while requester 0 waits
    p0 = preempt_cnt;
    bus.slice_len = 8'd4;
    bus.req = 4'b0101;
    exp_q.push_back(4'b0100);
    wait_sig(1, 1'b1, "t6_run_timeout");
    repeat (4) @(negedge clk);
    bus.done = 4'b0100;
    @(negedge clk);
    check("t6_collide_stop", 32'(bus.stop), 32'd1);
    check("t6_collide_preempt", 32'(bus.preempt), 32'd0);
    bus.done = '0;
    bus.req = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_sig(0, 1'b0, "t6_busy_fall_timeout");
    check("t6_preempt_total", 32'(preempt_cnt - p0), 32'd0);

    // Reset in RUN; pointer must return to requester 0 first
    wait_sig(1, 1'b1, "t6_run2_timeout");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.req = 4'b1111;
    @(negedge clk);
    check("t6_rst_grant", 32'(bus.grant), 32'd0);
    check("t6_rst_go", 32'(bus.go), 32'd0);
    check("t6_rst_stop", 32'(bus.stop), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_preempt", 32'(bus.preempt), 32'd0);
    rst = 1'b0;
    exp_q.push_back(4'b0001);
    wait_sig(0, 1'b1, "t6_regrant_timeout");
    bus.req = 4'b0000;
    bus.slice_len = 8'd0;
    wait_sig(0, 1'b0, "t6_busy_fall2_timeout");

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
